ctrl_seq_mc: RTL and testbench

- Parametrised multi-cycle control sequencer; successor to the two-state decode/ALU-op controller.
- Accepts one decoded instruction type at a time over a valid/ready handshake and sequences the register-file, ALU-buffer and data-memory strobes.
- Adds load/store sequencing with configurable memory latency, stall, flush, sticky illegal-type error and a retired-instruction counter.
- Sits between the decoder and the datapath in the RV32I core.

---
 rtl/ctrl_seq_mc.sv | 142 ++++++++++++++
 tb/tb_ctrl_seq_mc.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_mc.sv
// Multi-cycle control sequencer: steps one decoded instruction through DECODE/EXEC/MEM/WB
// and drives the register-file, ALU-buffer and data-memory strobes as Moore outputs.
module ctrl_seq_mc #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_type,
    input  logic             stall,
    input  logic             flush,
    input  logic             clear_error,
    output logic             alubuf1_load,
    output logic             alubuf2_load,
    output logic             is_imm,
    output logic             rf_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             error,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb, StError} state_e;

    localparam logic [2:0] TypeR     = 3'd0;
    localparam logic [2:0] TypeLoad  = 3'd2;
    localparam logic [2:0] TypeStore = 3'd3;
    localparam logic [3:0] MemLast   = 4'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic [3:0]       mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            type_q    <= TypeR;
            mem_cnt_q <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            mem_cnt_q <= mem_cnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        mem_cnt_d    = mem_cnt_q;
        retire       = 1'b0;
        instr_ready  = 1'b0;
        alubuf1_load = 1'b0;
        alubuf2_load = 1'b0;
        is_imm       = 1'b0;
        rf_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        error        = 1'b0;

        unique case (state_q)
            StIdle: begin
                instr_ready = !stall && !flush;
                if (instr_valid && instr_ready) begin
                    type_d  = instr_type;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alubuf1_load = 1'b1;
                alubuf2_load = 1'b1;
                state_d      = type_q[2] ? StError : StExec;
            end
            StExec: begin
                is_imm = (type_q != TypeR);
                if (type_q == TypeLoad || type_q == TypeStore) begin
                    mem_cnt_d = 4'd0;
                    state_d   = StMem;
                end else begin
                    rf_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = StIdle;
                end
            end
            StMem: begin
                is_imm    = 1'b1;
                mem_read  = (type_q == TypeLoad);
                mem_write = (type_q == TypeStore);
                mem_cnt_d = mem_cnt_q + 4'd1;
                if (mem_cnt_q == MemLast) begin
                    if (type_q == TypeLoad) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWb: begin
                rf_write = 1'b1;
                retire   = 1'b1;
                state_d  = StIdle;
            end
            StError: begin
                error = 1'b1;
                if (clear_error) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush beats stall; neither applies in IDLE or ERROR.
        if (state_q inside {StDecode, StExec, StMem, StWb}) begin
            if (flush) begin
                state_d      = StIdle;
                mem_cnt_d    = mem_cnt_q;
                retire       = 1'b0;
                alubuf1_load = 1'b0;
                alubuf2_load = 1'b0;
                is_imm       = 1'b0;
                rf_write     = 1'b0;
                mem_read     = 1'b0;
                mem_write    = 1'b0;
            end else if (stall) begin
                state_d      = state_q;
                mem_cnt_d    = mem_cnt_q;
                retire       = 1'b0;
                alubuf1_load = 1'b0;
                alubuf2_load = 1'b0;
                rf_write     = 1'b0;
            end
        end
    end

    assign retired_d     = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_ctrl_seq_mc.sv
// Scoreboard bench for ctrl_seq_mc: the driver queues hand-computed per-cycle expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_ctrl_seq_mc;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [2:0]       instr_type = 3'd0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             clear_error = 1'b0;
    logic             alubuf1_load, alubuf2_load, is_imm, rf_write, mem_read, mem_write, error;
    logic [CNT_W-1:0] retired_count;

    // Expected entry: {ready, alubuf1, alubuf2, is_imm, rf_write, mem_read, mem_write, error, cnt}
    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    ctrl_seq_mc #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_type(instr_type), .stall(stall), .flush(flush), .clear_error(clear_error),
        .alubuf1_load(alubuf1_load), .alubuf2_load(alubuf2_load), .is_imm(is_imm),
        .rf_write(rf_write), .mem_read(mem_read), .mem_write(mem_write), .error(error),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    // Monitor
    initial begin
        logic [11:0] e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {instr_ready, alubuf1_load, alubuf2_load, is_imm, rf_write, mem_read,
                     mem_write, error, retired_count};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check #%0d: got rdy/a1/a2/imm/rfw/mr/mw/err=%b cnt=%0d, want %b cnt=%0d",
                             n_checks, a[11:4], a[3:0], e[11:4], e[3:0]);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] t, input logic st, input logic fl,
                       input logic cl, input logic [7:0] eb, input int ec);
        @(posedge clock);
        #1;
        instr_valid = v;
        instr_type  = t;
        stall       = st;
        flush       = fl;
        clear_error = cl;
        exp_q.push_back({eb, 4'(ec)});
    endtask

    initial begin
        int c;
        #12 reset = 1'b1;

        // R_TYPE: accept, DECODE, EXEC, back in IDLE with one retire
        cyc(1, 3'd0, 0, 0, 0, 8'b1000_0000, 0);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 0);
        cyc(0, 3'd0, 0, 0, 0, 8'b0000_1000, 0);
        // LOAD (accepted here), two MEM cycles, WB; then back-to-back I_TYPE
        cyc(1, 3'd2, 0, 0, 0, 8'b1000_0000, 1);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 1);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0000, 1);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0100, 1);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0100, 1);
        cyc(0, 3'd0, 0, 0, 0, 8'b0000_1000, 1);
        cyc(1, 3'd1, 0, 0, 0, 8'b1000_0000, 2);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 2);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_1000, 2);
        // STORE with three stall cycles in the first MEM cycle
        cyc(1, 3'd3, 0, 0, 0, 8'b1000_0000, 3);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 3);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0000, 3);
        for (int i = 0; i < 3; i++) cyc(0, 3'd0, 1, 0, 0, 8'b0001_0010, 3);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0010, 3);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0010, 3);
        // Illegal type 5: DECODE, then sticky ERROR (flush and stall must not leave it)
        cyc(1, 3'd5, 0, 0, 0, 8'b1000_0000, 4);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 4);
        for (int i = 0; i < 10; i++)
            cyc(0, 3'd0, (i == 5), (i == 3), 0, 8'b0000_0001, 4);
        cyc(0, 3'd0, 0, 0, 1, 8'b0000_0001, 4);
        // LOAD flushed (with stall) in MEM: no retire
        cyc(1, 3'd2, 0, 0, 0, 8'b1000_0000, 4);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 4);
        cyc(0, 3'd0, 0, 0, 0, 8'b0001_0000, 4);
        cyc(0, 3'd0, 1, 1, 0, 8'b0000_0000, 4);
        // Stall and flush in IDLE block capture
        cyc(1, 3'd0, 1, 0, 0, 8'b0000_0000, 4);
        cyc(1, 3'd0, 0, 1, 0, 8'b0000_0000, 4);
        // R_TYPE stalled in DECODE and EXEC
        cyc(1, 3'd0, 0, 0, 0, 8'b1000_0000, 4);
        cyc(0, 3'd0, 1, 0, 0, 8'b0000_0000, 4);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 4);
        cyc(0, 3'd0, 1, 0, 0, 8'b0000_0000, 4);
        cyc(0, 3'd0, 0, 0, 0, 8'b0000_1000, 4);
        // 16 R_TYPE: count passes 15 -> 0 and returns to 5
        for (int k = 0; k < 16; k++) begin
            c = (5 + k) % 16;
            cyc(1, 3'd0, 0, 0, 0, 8'b1000_0000, c);
            cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, c);
            cyc(0, 3'd0, 0, 0, 0, 8'b0000_1000, c);
        end
        // Async reset in the middle of EXEC, released between edges
        cyc(1, 3'd0, 0, 0, 0, 8'b1000_0000, 5);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 5);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        #1 reset = 1'b0;
        exp_q.push_back({8'b1000_0000, 4'd0});
        cyc(0, 3'd0, 0, 0, 0, 8'b1000_0000, 0);
        #1 reset = 1'b1;
        cyc(1, 3'd0, 0, 0, 0, 8'b1000_0000, 0);
        cyc(0, 3'd0, 0, 0, 0, 8'b0110_0000, 0);
        cyc(0, 3'd0, 0, 0, 0, 8'b0000_1000, 0);
        cyc(0, 3'd0, 0, 0, 0, 8'b1000_0000, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
